// File: rtl/bch_encoder_p8.sv
// Byte-parallel systematic BCH(8191) encoder over GF(2^13), t=8, shortened to 4096+104 bits.
// Message bytes pass straight through; the 104-bit remainder is then shifted out a byte at a time.
module bch_encoder_p8 #(
  parameter int M     = 13,
  parameter int T     = 8,
  parameter int PAR_W = 8,
  parameter int NPAR  = 104
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sel,
  input  logic [PAR_W-1:0] message,
  output logic [PAR_W-1:0] code_o
);

  // Low-order terms of p(x) = x^13 + x^4 + x^3 + x + 1
  localparam logic [M-1:0] PRIM_LOW = M'('h001B);
  localparam logic [M-1:0] ALPHA    = M'(2);

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc ^= aa;
      aa = {aa[M-2:0], 1'b0} ^ (aa[M-1] ? PRIM_LOW : '0);
    end
    return acc;
  endfunction

  // g(x) = product of the minimal polynomials of alpha^1, alpha^3, ..., alpha^(2T-1).
  // Each minimal polynomial is built as the product of (x + beta^(2^j)) over its conjugates.
  function automatic logic [NPAR:0] gen_poly();
    logic [NPAR:0]        g;
    logic [NPAR:0]        gn;
    logic [(M+1)*M-1:0]   mp;
    logic [(M+1)*M-1:0]   nw;
    logic [M-1:0]         beta;
    g    = '0;
    g[0] = 1'b1;
    for (int c = 1; c < 2*T; c += 2) begin
      beta = M'(1);
      for (int n = 0; n < c; n++) beta = gf_mul(beta, ALPHA);
      mp       = '0;
      mp[M-1:0] = M'(1);
      for (int j = 0; j < M; j++) begin
        nw = '0;
        for (int k = 0; k <= M; k++) begin
          nw[k*M +: M] = gf_mul(beta, mp[k*M +: M]);
          if (k > 0) nw[k*M +: M] = nw[k*M +: M] ^ mp[(k-1)*M +: M];
        end
        mp   = nw;
        beta = gf_mul(beta, beta);
      end
      gn = '0;
      for (int k = 0; k <= M; k++) begin
        if (mp[k*M]) gn ^= (g << k);
      end
      g = gn;
    end
    return g;
  endfunction

  localparam logic [NPAR:0] GEN_POLY = gen_poly();

  // x^(NPAR+k) mod g(x): the feedback column for bit k of the fold vector
  function automatic logic [NPAR-1:0] col_for(input int k);
    logic [NPAR-1:0] c;
    c = GEN_POLY[NPAR-1:0];
    for (int i = 0; i < k; i++) begin
      c = {c[NPAR-2:0], 1'b0} ^ (c[NPAR-1] ? GEN_POLY[NPAR-1:0] : '0);
    end
    return c;
  endfunction

  logic [NPAR-1:0]  r_reg;
  logic             prev_sel_reg;
  logic [PAR_W-1:0] code_reg;

  logic [NPAR-1:0]  base;
  logic [NPAR-1:0]  shifted;
  logic [NPAR-1:0]  fold;
  logic [NPAR-1:0]  r_msg_next;
  logic [NPAR-1:0]  r_par_next;
  logic [PAR_W-1:0] f;
  logic [PAR_W-1:0] par_byte;
  logic [NPAR-1:0]  term [PAR_W];

  // A new block begins whenever sel rises, so the remainder restarts from zero then
  assign base    = prev_sel_reg ? r_reg : '0;
  assign shifted = {base[NPAR-PAR_W-1:0], {PAR_W{1'b0}}};

  genvar gi;
  generate
    for (gi = 0; gi < PAR_W; gi++) begin : g_xor
      localparam logic [NPAR-1:0] COL = col_for(gi);
      assign f[PAR_W-1-gi] = base[NPAR-1-gi] ^ message[gi];
      assign term[gi]      = f[gi] ? COL : '0;
      assign par_byte[gi]  = r_reg[NPAR-1-gi];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int k = 0; k < PAR_W; k++) fold = fold ^ term[k];
  end

  assign r_msg_next = shifted ^ fold;
  assign r_par_next = {r_reg[NPAR-PAR_W-1:0], {PAR_W{1'b0}}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg        <= '0;
      prev_sel_reg <= 1'b0;
      code_reg     <= '0;
    end else if (!start) begin
      r_reg        <= '0;
      prev_sel_reg <= 1'b0;
      code_reg     <= '0;
    end else begin
      prev_sel_reg <= sel;
      if (sel) begin
        r_reg    <= r_msg_next;
        code_reg <= message;
      end else begin
        r_reg    <= r_par_next;
        code_reg <= par_byte;
      end
    end
  end

  assign code_o = code_reg;

endmodule

// File: tb/tb_bch_encoder_p8.sv
// Randomized bench for bch_encoder_p8: long-division reference model, generator built from
// GF(2^13) log/antilog tables, codeword divisibility and single-bit-flip detection.
module tb_bch_encoder_p8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sel;
  logic [7:0] message;
  logic [7:0] code_o;

  always #5 clk = ~clk;

  bch_encoder_p8 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sel     (sel),
    .message (message),
    .code_o  (code_o)
  );

  int vectors = 0;
  int errors  = 0;

  logic [12:0]  exp_t [0:8190];
  int           log_t [0:8191];
  logic [12:0]  gc    [0:104];
  logic [104:0] g_tb;
  logic [7:0]   msg_mem [0:511];
  logic [7:0]   got_mem [0:527];

  task automatic check_eq(input string tag, input logic [103:0] got, input logic [103:0] expv);
    vectors++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [12:0] tbl_mul(input logic [12:0] a, input logic [12:0] b);
    if (a == 0 || b == 0) return 13'd0;
    return exp_t[(log_t[a] + log_t[b]) % 8191];
  endfunction

  // g(x) as the product of (x + alpha^e) over every exponent in the cyclotomic cosets of 1,3,..,15
  task automatic build_gen();
    logic [13:0] v;
    int deg;
    int e;
    v = 14'h1;
    for (int n = 0; n < 8191; n++) begin
      exp_t[n] = v[12:0];
      log_t[v] = n;
      v = v << 1;
      if (v[13]) v = v ^ 14'h201B;
    end
    for (int k = 0; k <= 104; k++) gc[k] = 13'd0;
    gc[0] = 13'd1;
    deg = 0;
    for (int i = 1; i < 16; i += 2) begin
      e = i;
      for (int j = 0; j < 13; j++) begin
        for (int k = deg + 1; k >= 1; k--) gc[k] = gc[k-1] ^ tbl_mul(exp_t[e], gc[k]);
        gc[0] = tbl_mul(exp_t[e], gc[0]);
        deg++;
        e = (e * 2) % 8191;
      end
    end
    for (int k = 0; k <= 104; k++) g_tb[k] = gc[k][0];
  endtask

  // Remainder of x^104 * m(x) mod g(x), bit by bit, earliest bit = highest degree
  function automatic logic [103:0] ref_rem();
    logic [103:0] r;
    logic fb;
    r = '0;
    for (int b = 0; b < 512; b++) begin
      for (int i = 0; i < 8; i++) begin
        fb = r[103] ^ msg_mem[b][i];
        r  = {r[102:0], 1'b0};
        if (fb) r = r ^ g_tb[103:0];
      end
    end
    return r;
  endfunction

  function automatic logic [103:0] cw_rem();
    logic [103:0] r;
    logic top;
    r = '0;
    for (int b = 0; b < 525; b++) begin
      for (int i = 0; i < 8; i++) begin
        top = r[103];
        r   = {r[102:0], got_mem[b][i]};
        if (top) r = r ^ g_tb[103:0];
      end
    end
    return r;
  endfunction

  task automatic step(input logic s, input logic sl, input logic [7:0] m, output logic [7:0] q);
    start   = s;
    sel     = sl;
    message = m;
    @(posedge clk);
    #1;
    q = code_o;
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 512; b++) msg_mem[b] = 8'($urandom);
  endtask

  task automatic encode_block(input string name, input int npar);
    logic [103:0] rem;
    logic [7:0]   q;
    logic [7:0]   e;
    int           p;
    int           err0;
    err0 = errors;
    rem  = ref_rem();
    for (int b = 0; b < 512; b++) begin
      step(1'b1, 1'b1, msg_mem[b], q);
      check_eq("systematic", 104'(q), 104'(msg_mem[b]));
      got_mem[b] = q;
    end
    for (int j = 0; j < npar; j++) begin
      for (int i = 0; i < 8; i++) e[i] = (j < 13) ? rem[103 - 8*j - i] : 1'b0;
      step(1'b1, 1'b0, 8'($urandom), q);
      check_eq("parity", 104'(q), 104'(e));
      got_mem[512 + j] = q;
    end
    if (npar >= 13) begin
      check_eq("divisible", cw_rem(), 104'd0);
      p = $urandom_range(4199, 0);
      got_mem[p/8][p%8] = ~got_mem[p/8][p%8];
      check_eq("flip_detect", 104'(cw_rem() != 0), 104'd1);
      got_mem[p/8][p%8] = ~got_mem[p/8][p%8];
    end
    $display("block %s: parity cycles %0d, model remainder %h, new miscompares %0d",
             name, npar, rem, errors - err0);
  endtask

  initial begin
    logic [7:0] q;
    logic [7:0] gb;
    reset   = 1'b0;
    start   = 1'b0;
    sel     = 1'b0;
    message = 8'h00;
    build_gen();

    // Held in reset, then enabled-off: output stays zero whatever the inputs do
    for (int c = 0; c < 4; c++) begin
      step(1'($urandom), 1'($urandom), 8'($urandom), q);
      check_eq("reset_idle", 104'(q), 104'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'($urandom), 8'($urandom), q);
      check_eq("start_idle", 104'(q), 104'd0);
    end
    $display("idle: reset and start=0 cycles applied");

    for (int b = 0; b < 512; b++) msg_mem[b] = 8'h00;
    encode_block("all_zero", 13);

    msg_mem[511] = 8'h80;
    encode_block("impulse", 13);
    for (int j = 0; j < 13; j++) begin
      for (int i = 0; i < 8; i++) gb[i] = g_tb[103 - 8*j - i];
      check_eq("impulse_gen", 104'(got_mem[512 + j]), 104'(gb));
    end

    fill_rand();
    encode_block("random", 13);
    fill_rand();
    encode_block("b2b_second", 13);
    fill_rand();
    encode_block("short_parity", 5);
    fill_rand();
    encode_block("after_short", 13);
    fill_rand();
    encode_block("long_parity", 16);

    // Abort by dropping start after 200 bytes
    fill_rand();
    for (int b = 0; b < 200; b++) step(1'b1, 1'b1, msg_mem[b], q);
    step(1'b0, 1'b1, 8'($urandom), q);
    check_eq("abort_start", 104'(q), 104'd0);
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, 8'($urandom), q);
      check_eq("abort_cleared", 104'(q), 104'd0);
    end
    fill_rand();
    encode_block("after_start_abort", 13);

    // Abort by asynchronous reset after 200 bytes
    fill_rand();
    for (int b = 0; b < 200; b++) step(1'b1, 1'b1, msg_mem[b], q);
    reset = 1'b0;
    #1;
    check_eq("async_reset", 104'(code_o), 104'd0);
    #1 reset = 1'b1;
    step(1'b1, 1'b0, 8'($urandom), q);
    check_eq("reset_cleared", 104'(q), 104'd0);
    fill_rand();
    encode_block("after_reset_abort", 13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
